// File: rtl/uart_tx_fifo_if.sv
// Write-side handshake between a controller and the UART transmitter FIFO.
// A word moves on any clock edge where Tx_DV and Tx_Ready are both high.
interface uart_tx_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic                 Tx_DV;
    logic [DATA_BITS-1:0] Tx_Byte;
    logic                 Tx_Ready;

    modport master (
        output Tx_DV,
        output Tx_Byte,
        input  Tx_Ready
    );

    modport slave (
        input  Tx_DV,
        input  Tx_Byte,
        output Tx_Ready
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO. Frame settings are captured when a frame starts.
// Queued frames go out back-to-back with no idle gap between them.
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CLK_DIV_W  = 16
) (
    input  logic                        i_Clock,
    input  logic                        i_Reset,
    input  logic [CLK_DIV_W-1:0]        i_Clks_Per_Bit,
    input  logic                        i_Parity_En,
    input  logic                        i_Parity_Odd,
    input  logic                        i_Two_Stop,
    uart_tx_fifo_if.slave               tx_if,
    output logic                        o_Tx_Serial,
    output logic                        o_Tx_Active,
    output logic                        o_Tx_Done,
    output logic [$clog2(FIFO_DEPTH):0] o_Fifo_Count
);
    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int BIT_W  = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);
    localparam logic [ADDR_W:0]  DEPTH_CNT = (ADDR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]    wr_ptr_reg;
    logic [ADDR_W-1:0]    rd_ptr_reg;
    logic [ADDR_W:0]      count_reg;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;

    state_t               state_reg;
    state_t               state_next;
    logic [CLK_DIV_W-1:0] baud_cnt_reg;
    logic [CLK_DIV_W-1:0] baud_cnt_next;
    logic [BIT_W-1:0]     bit_idx_reg;
    logic [BIT_W-1:0]     bit_idx_next;
    logic [CLK_DIV_W-1:0] period_reg;
    logic [CLK_DIV_W-1:0] cpb_m1;
    logic                 par_en_reg;
    logic                 par_odd_reg;
    logic                 two_stop_reg;
    logic [DATA_BITS-1:0] data_reg;
    logic                 bit_end;
    logic                 frame_end;
    logic                 line_bit;

    logic                 serial_reg;
    logic                 active_reg;
    logic                 done_pend_reg;
    logic                 done_reg;

    assign fifo_full      = (count_reg == DEPTH_CNT);
    assign fifo_empty     = (count_reg == '0);
    assign push           = tx_if.Tx_DV && !fifo_full;
    assign tx_if.Tx_Ready = !fifo_full;

    // A divisor of zero behaves like one clock per bit.
    assign cpb_m1  = (i_Clks_Per_Bit == '0) ? '0 : i_Clks_Per_Bit - CLK_DIV_W'(1);
    assign bit_end = (baud_cnt_reg == '0);

    // Storage has no reset so it maps onto RAM; the popped word lands in data_reg.
    always_ff @(posedge i_Clock) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= tx_if.Tx_Byte;
        end
        if (pop) begin
            data_reg <= fifo_mem[rd_ptr_reg];
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_comb begin
        state_next    = state_reg;
        baud_cnt_next = baud_cnt_reg;
        bit_idx_next  = bit_idx_reg;
        pop           = 1'b0;
        frame_end     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop           = 1'b1;
                    state_next    = ST_START;
                    baud_cnt_next = cpb_m1;
                    bit_idx_next  = '0;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_next    = ST_DATA;
                    baud_cnt_next = period_reg;
                    bit_idx_next  = '0;
                end else begin
                    baud_cnt_next = baud_cnt_reg - 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    baud_cnt_next = period_reg;
                    if (bit_idx_reg == LAST_BIT) begin
                        state_next   = par_en_reg ? ST_PARITY : ST_STOP;
                        bit_idx_next = '0;
                    end else begin
                        bit_idx_next = bit_idx_reg + 1'b1;
                    end
                end else begin
                    baud_cnt_next = baud_cnt_reg - 1'b1;
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_next    = ST_STOP;
                    baud_cnt_next = period_reg;
                    bit_idx_next  = '0;
                end else begin
                    baud_cnt_next = baud_cnt_reg - 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (two_stop_reg && (bit_idx_reg == '0)) begin
                        bit_idx_next  = BIT_W'(1);
                        baud_cnt_next = period_reg;
                    end else begin
                        // Chain straight into the next start bit when a word is waiting.
                        frame_end = 1'b1;
                        if (!fifo_empty) begin
                            pop           = 1'b1;
                            state_next    = ST_START;
                            baud_cnt_next = cpb_m1;
                            bit_idx_next  = '0;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end
                end else begin
                    baud_cnt_next = baud_cnt_reg - 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        line_bit = 1'b1;
        case (state_reg)
            ST_START:  line_bit = 1'b0;
            ST_DATA:   line_bit = data_reg[bit_idx_reg];
            ST_PARITY: line_bit = (^data_reg) ^ par_odd_reg;
            default:   line_bit = 1'b1;
        endcase
    end

    // Line, active and done are registered views of the state, so done trails the last stop clock on the line.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_reg     <= ST_IDLE;
            baud_cnt_reg  <= '0;
            bit_idx_reg   <= '0;
            period_reg    <= '0;
            par_en_reg    <= 1'b0;
            par_odd_reg   <= 1'b0;
            two_stop_reg  <= 1'b0;
            serial_reg    <= 1'b1;
            active_reg    <= 1'b0;
            done_pend_reg <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            baud_cnt_reg <= baud_cnt_next;
            bit_idx_reg  <= bit_idx_next;
            if (pop) begin
                period_reg   <= cpb_m1;
                par_en_reg   <= i_Parity_En;
                par_odd_reg  <= i_Parity_Odd;
                two_stop_reg <= i_Two_Stop;
            end
            serial_reg    <= line_bit;
            active_reg    <= (state_reg != ST_IDLE);
            done_pend_reg <= frame_end;
            done_reg      <= done_pend_reg;
        end
    end

    assign o_Tx_Serial  = serial_reg;
    assign o_Tx_Active  = active_reg;
    assign o_Tx_Done    = done_reg;
    assign o_Fifo_Count = count_reg;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed and randomised bench for uart_tx_fifo; expected line waveforms come from
// a frame model built from the data word and the frame settings.
module tb_uart_tx_fifo;
    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic [15:0] cpb;
    logic        par_en;
    logic        par_odd;
    logic        two_stop;
    logic        o_Tx_Serial;
    logic        o_Tx_Active;
    logic        o_Tx_Done;
    logic [2:0]  o_Fifo_Count;

    uart_tx_fifo_if #(.DATA_BITS(8)) tx_if ();

    uart_tx_fifo #(
        .DATA_BITS (8),
        .FIFO_DEPTH(DEPTH),
        .CLK_DIV_W (16)
    ) dut (
        .i_Clock       (clk),
        .i_Reset       (rst),
        .i_Clks_Per_Bit(cpb),
        .i_Parity_En   (par_en),
        .i_Parity_Odd  (par_odd),
        .i_Two_Stop    (two_stop),
        .tx_if         (tx_if),
        .o_Tx_Serial   (o_Tx_Serial),
        .o_Tx_Active   (o_Tx_Active),
        .o_Tx_Done     (o_Tx_Done),
        .o_Fifo_Count  (o_Fifo_Count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] burst[8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bit k of a frame: start, 8 data bits LSB first, optional parity, stop bits.
    function automatic logic frame_bit(input logic [7:0] d, input bit pe, input bit po, input int k);
        int ones;
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (pe && k == 9) begin
            ones = 0;
            for (int j = 0; j < 8; j++) ones += int'(d[j]);
            return logic'((ones % 2) != 0) ^ logic'(po);
        end
        return 1'b1;
    endfunction

    // Called at the negedge holding the first start-bit sample; returns at the negedge after the frame.
    task automatic check_frame(input logic [7:0] d, input int p, input bit pe, input bit po,
                               input bit ts, input int abort_at);
        int pp;
        int len;
        pp  = (p == 0) ? 1 : p;
        len = (1 + 8 + int'(pe) + 1 + int'(ts)) * pp;
        for (int i = 0; i < len; i++) begin
            if (i == abort_at) return;
            chk($sformatf("line[%02h] s%0d", d, i), o_Tx_Serial, frame_bit(d, pe, po, i / pp));
            chk("active_in_frame", o_Tx_Active, 1);
            if (i > 0) chk("done_mid_frame", o_Tx_Done, 0);
            @(negedge clk);
        end
        chk($sformatf("done_pulse[%02h]", d), o_Tx_Done, 1);
    endtask

    // Push n words one per cycle while checking the resulting frames; optionally
    // change the divisor mid-frame or reset the block partway through the first frame.
    task automatic run_burst(input int n, input int change_at, input int new_cpb, input int abort_at);
        int  p;
        int  n_acc;
        bit  pe, po, ts;
        p  = int'(cpb);
        pe = par_en;
        po = par_odd;
        ts = two_stop;
        n_acc = 0;
        fork
            begin
                for (int k = 0; k < n; k++) begin
                    int  queued;
                    bit  exp_ready;
                    queued    = n_acc - ((k >= 2) ? 1 : 0);
                    exp_ready = (queued < DEPTH);
                    chk($sformatf("ready_push%0d", k), tx_if.Tx_Ready, exp_ready);
                    tx_if.Tx_DV   = 1'b1;
                    tx_if.Tx_Byte = burst[k];
                    if (exp_ready) begin
                        exp_q.push_back(burst[k]);
                        n_acc++;
                    end
                    @(negedge clk);
                end
                tx_if.Tx_DV = 1'b0;
                chk("fifo_count_after_push", o_Fifo_Count, n_acc - ((n >= 2) ? 1 : 0));
            end
            begin
                if (change_at >= 0) begin
                    repeat (change_at) @(negedge clk);
                    cpb = 16'(new_cpb);
                end
            end
            begin
                @(negedge clk);
                chk("latency_edge0", o_Tx_Serial, 1);
                @(negedge clk);
                chk("latency_edge1", o_Tx_Serial, 1);
                @(negedge clk);
                if (abort_at >= 0) begin
                    check_frame(exp_q[0], p, pe, po, ts, abort_at);
                end else begin
                    int nf;
                    nf = (n <= DEPTH + 1) ? n : DEPTH + 1;
                    for (int f = 0; f < nf; f++) begin
                        int pf;
                        pf = (f == 0 || change_at < 0) ? p : new_cpb;
                        check_frame(exp_q.pop_front(), pf, pe, po, ts, -1);
                    end
                    chk("idle_line", o_Tx_Serial, 1);
                    chk("idle_active", o_Tx_Active, 0);
                    @(negedge clk);
                    chk("done_one_cycle", o_Tx_Done, 0);
                    chk("idle_count", o_Fifo_Count, 0);
                end
            end
        join
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        cpb           = 16'd4;
        par_en        = 1'b0;
        par_odd       = 1'b0;
        two_stop      = 1'b0;
        tx_if.Tx_DV   = 1'b0;
        tx_if.Tx_Byte = 8'h00;

        // Reset held for three cycles.
        repeat (3) @(negedge clk);
        chk("rst_serial", o_Tx_Serial, 1);
        chk("rst_ready", tx_if.Tx_Ready, 1);
        chk("rst_count", o_Fifo_Count, 0);
        chk("rst_active", o_Tx_Active, 0);
        chk("rst_done", o_Tx_Done, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single 0xA5 frame, 4 clocks per bit.
        burst[0] = 8'hA5;
        run_burst(1, -1, 0, -1);

        // Even then odd parity on 0x07, then two stop bits back-to-back.
        par_en = 1'b1; par_odd = 1'b0; burst[0] = 8'h07;
        run_burst(1, -1, 0, -1);
        par_odd = 1'b1;
        run_burst(1, -1, 0, -1);
        par_en = 1'b0; par_odd = 1'b0; two_stop = 1'b1;
        burst[0] = 8'h3C; burst[1] = 8'hC3;
        run_burst(2, -1, 0, -1);
        two_stop = 1'b0;

        // Six-cycle write burst into a four-deep FIFO: fifth word fits, sixth is dropped.
        cpb = 16'd2;
        for (int k = 0; k < 6; k++) burst[k] = 8'(k + 1);
        run_burst(6, -1, 0, -1);

        // Divisor of zero, then a divisor change in the middle of a frame.
        cpb = 16'd0; burst[0] = 8'h5A;
        run_burst(1, -1, 0, -1);
        cpb = 16'd3; burst[0] = 8'h81; burst[1] = 8'h7E;
        run_burst(2, 5, 2, -1);

        // Randomised frames and settings.
        for (int r = 0; r < 10; r++) begin
            int n;
            n        = int'($urandom_range(1, 5));
            cpb      = 16'($urandom_range(0, 3));
            par_en   = 1'($urandom_range(0, 1));
            par_odd  = 1'($urandom_range(0, 1));
            two_stop = 1'($urandom_range(0, 1));
            for (int k = 0; k < n; k++) burst[k] = 8'($urandom);
            run_burst(n, -1, 0, -1);
        end

        // Reset during data bit 3 with two words still queued.
        cpb = 16'd4; par_en = 1'b0; par_odd = 1'b0; two_stop = 1'b0;
        burst[0] = 8'hF0; burst[1] = 8'h11; burst[2] = 8'h22;
        run_burst(3, -1, 0, 17);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_serial", o_Tx_Serial, 1);
        chk("abort_active", o_Tx_Active, 0);
        chk("abort_done", o_Tx_Done, 0);
        chk("abort_count", o_Fifo_Count, 0);
        chk("abort_ready", tx_if.Tx_Ready, 1);
        rst = 1'b0;
        exp_q.delete();
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            chk("post_abort_line", o_Tx_Serial, 1);
            chk("post_abort_done", o_Tx_Done, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
